// File: rtl/higher_memory_responder.sv
// Memory-side responder for the cache higher-memory request port.
// HIGHER_MEM_LATENCY_JITTER_EN adds 0-3 LFSR-driven wait cycles per request.
package torrence_types;
   typedef enum logic [1:0] {
      NO_OPERATION = 2'd0,
      LOAD         = 2'd1,
      STORE        = 2'd2,
      CLEAR        = 2'd3
   } memory_operation_e;
endpackage

module higher_memory_responder
   import torrence_types::*;
#(
   parameter int XLEN        = 32,
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [XLEN-1:0]   req_address,
   input  memory_operation_e req_operation,
   input  logic [XLEN-1:0]   req_store_word,
   input  logic              req_valid,
   output logic [XLEN-1:0]   req_loaded_word,
   output logic              req_fulfilled,
   output logic              busy
);
   localparam int IW = $clog2(DEPTH_WORDS);
   localparam int CW = 5;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESPOND
   } state_e;

   state_e            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [IW-1:0]     idx_q, idx_d;
   memory_operation_e op_q, op_d;
   logic [XLEN-1:0]   data_q, data_d;
   logic [XLEN-1:0]   loaded_q;
   logic              mem_we;
   logic              load_en;
   logic [CW-1:0]     extra;
   logic [XLEN-1:0]   mem [DEPTH_WORDS];

   // Byte offset and wrap bits take no part in word selection
   logic unused_addr_bits;
   assign unused_addr_bits =
      ^{req_address[XLEN-1:IW+2], req_address[1:0]};

`ifdef HIGHER_MEM_LATENCY_JITTER_EN
   logic [7:0] lfsr_q, lfsr_d;

   always_comb begin
      lfsr_d = lfsr_q;
      if (state_q == IDLE && req_valid)
         lfsr_d = {lfsr_q[6:0],
                   lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
   end

   assign extra = {{(CW-2){1'b0}}, lfsr_q[1:0]};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         lfsr_q <= 8'hA5;
      else
         lfsr_q <= lfsr_d;
   end
`else
   assign extra = '0;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      op_d    = op_q;
      data_d  = data_q;
      mem_we  = 1'b0;
      load_en = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               idx_d   = req_address[IW+1:2];
               op_d    = req_operation;
               data_d  = req_store_word;
               cnt_d   = CW'(LATENCY - 1) + extra;
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               state_d = RESPOND;
               mem_we  = (op_q == STORE);
               load_en = (op_q == LOAD);
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         RESPOND: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         idx_q    <= '0;
         op_q     <= NO_OPERATION;
         data_q   <= '0;
         loaded_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         op_q    <= op_d;
         data_q  <= data_d;
         if (load_en)
            loaded_q <= mem[idx_q];
      end
   end

   // Storage is deliberately outside the reset domain
   always_ff @(posedge clk) begin
      if (mem_we)
         mem[idx_q] <= data_q;
   end

   assign req_loaded_word = loaded_q;
   assign req_fulfilled   = (state_q == RESPOND);
   assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_higher_memory_responder.sv
// Randomized self-checking bench for higher_memory_responder.
// Reference model: word array keyed by (address/4) mod depth.
module tb_higher_memory_responder;
   import torrence_types::*;

   localparam int XLEN  = 32;
   localparam int DEPTH = 1024;
   localparam int LAT   = 4;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic [XLEN-1:0]   req_address = '0;
   memory_operation_e req_operation = NO_OPERATION;
   logic [XLEN-1:0]   req_store_word = '0;
   logic              req_valid = 1'b0;
   logic [XLEN-1:0]   req_loaded_word;
   logic              req_fulfilled;
   logic              busy;

   int total = 0;
   int bad = 0;

   logic [XLEN-1:0] mem_m [int];
   logic [XLEN-1:0] last_load;
   logic [7:0]      lfsr_m;

   higher_memory_responder #(
      .XLEN(XLEN),
      .DEPTH_WORDS(DEPTH),
      .LATENCY(LAT)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .req_address(req_address),
      .req_operation(req_operation),
      .req_store_word(req_store_word),
      .req_valid(req_valid),
      .req_loaded_word(req_loaded_word),
      .req_fulfilled(req_fulfilled),
      .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic int word_of(input logic [XLEN-1:0] a);
      return int'((a / 4) % DEPTH);
   endfunction

   // Latency the next accepted request should see
   function automatic int next_latency();
      int l;
      l = LAT;
`ifdef HIGHER_MEM_LATENCY_JITTER_EN
      l = l + int'(lfsr_m[1:0]);
      lfsr_m = {lfsr_m[6:0],
                lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
`endif
      return l;
   endfunction

   function automatic void model_apply(input logic [XLEN-1:0] a,
                                       input memory_operation_e op,
                                       input logic [XLEN-1:0] d);
      if (op == STORE)
         mem_m[word_of(a)] = d;
      else if (op == LOAD)
         last_load = mem_m[word_of(a)];
   endfunction

   task automatic apply_reset();
      @(negedge clk);
      req_valid = 1'b0;
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      lfsr_m = 8'hA5;
      last_load = '0;
   endtask

   // One request held until fulfilled; checks timing, pulse and data
   task automatic do_req(input logic [XLEN-1:0] a,
                         input memory_operation_e op,
                         input logic [XLEN-1:0] d,
                         input string nm,
                         output int lat_obs);
      int  lat;
      int  k;
      bit  seen;
      lat = next_latency();
      @(negedge clk);
      req_address = a;
      req_operation = op;
      req_store_word = d;
      req_valid = 1'b1;
      seen = 0;
      k = 0;
      lat_obs = -1;
      while (!seen && k < 40) begin
         @(negedge clk);
         k++;
         if (k == 1) begin
            total++;
            if (busy !== 1'b1) begin
               bad++;
               $display("FAIL %s busy_after_capture got=%b want=1", nm, busy);
            end
         end
         if (req_fulfilled === 1'b1) seen = 1;
      end
      lat_obs = seen ? k - 1 : -1;
      total++;
      if (lat_obs !== lat) begin
         bad++;
         $display("FAIL %s latency got=%0d want=%0d", nm, lat_obs, lat);
      end
      if (!seen) begin
         apply_reset();
         return;
      end
      model_apply(a, op, d);
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL %s busy_in_respond got=%b want=1", nm, busy);
      end
      total++;
      if (req_loaded_word !== last_load) begin
         bad++;
         $display("FAIL %s loaded_word got=%h want=%h",
                  nm, req_loaded_word, last_load);
      end
      req_valid = 1'b0;
      @(negedge clk);
      total++;
      if (req_fulfilled !== 1'b0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL %s after_pulse fulfilled=%b busy=%b want 0/0",
                  nm, req_fulfilled, busy);
      end
      total++;
      if (req_loaded_word !== last_load) begin
         bad++;
         $display("FAIL %s loaded_hold got=%h want=%h",
                  nm, req_loaded_word, last_load);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if (req_fulfilled !== 1'b0 || busy !== 1'b0 ||
          req_loaded_word !== '0) begin
         bad++;
         $display("FAIL reset_state fulfilled=%b busy=%b word=%h want 0/0/0",
                  req_fulfilled, busy, req_loaded_word);
      end
      reset_n = 1'b1;
      lfsr_m = 8'hA5;
      last_load = '0;
   endtask

   task automatic test_store_load();
      int l;
      do_req(32'h40, STORE, 32'hDEADBEEF, "store_40", l);
      do_req(32'h40, LOAD, 32'h0, "load_40", l);
      total++;
      if (req_loaded_word !== 32'hDEADBEEF) begin
         bad++;
         $display("FAIL load_40_value got=%h want=deadbeef", req_loaded_word);
      end
   endtask

   task automatic test_wrap();
      int l;
      do_req(32'h0, STORE, 32'h11, "store_0", l);
      do_req(32'(DEPTH * 4), LOAD, 32'h0, "load_wrap", l);
      total++;
      if (req_loaded_word !== 32'h11) begin
         bad++;
         $display("FAIL load_wrap_value got=%h want=11", req_loaded_word);
      end
      do_req(32'h40, LOAD, 32'h0, "load_40_again", l);
      do_req(32'h3, LOAD, 32'h0, "load_offset", l);
      total++;
      if (req_loaded_word !== 32'h11) begin
         bad++;
         $display("FAIL load_offset_value got=%h want=11", req_loaded_word);
      end
   endtask

   task automatic test_other_ops();
      int l;
      do_req(32'h40, NO_OPERATION, 32'h1234, "nop_40", l);
      do_req(32'h40, CLEAR, 32'h5678, "clear_40", l);
      do_req(32'h40, LOAD, 32'h0, "load_after_other", l);
   endtask

   task automatic test_reset_abort();
      int l;
      do_req(32'h8, STORE, 32'h5555AAAA, "preload_8", l);
      void'(next_latency());
      @(negedge clk);
      req_address = 32'h8;
      req_operation = STORE;
      req_store_word = 32'h22;
      req_valid = 1'b1;
      repeat (2) @(negedge clk);
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL abort_busy_before_reset got=%b want=1", busy);
      end
      reset_n = 1'b0;
      #1;
      total++;
      if (req_fulfilled !== 1'b0 || busy !== 1'b0 ||
          req_loaded_word !== '0) begin
         bad++;
         $display("FAIL abort_reset_outputs f=%b b=%b w=%h want 0/0/0",
                  req_fulfilled, busy, req_loaded_word);
      end
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         total++;
         if (req_fulfilled !== 1'b0) begin
            bad++;
            $display("FAIL abort_pulse_in_reset got=%b want=0", req_fulfilled);
         end
      end
      req_valid = 1'b0;
      reset_n = 1'b1;
      lfsr_m = 8'hA5;
      last_load = '0;
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || req_loaded_word !== '0) begin
         bad++;
         $display("FAIL abort_post_reset busy=%b word=%h want 0/0",
                  busy, req_loaded_word);
      end
      do_req(32'h8, LOAD, 32'h0, "load_8_after_abort", l);
      total++;
      if (req_loaded_word !== 32'h5555AAAA) begin
         bad++;
         $display("FAIL abort_no_write got=%h want=5555aaaa", req_loaded_word);
      end
   endtask

   task automatic test_back_to_back();
      logic [XLEN-1:0] addrs [3];
      int lat;
      int c;
      int last_c;
      int pulses;
      int want;
      addrs[0] = 32'h40;
      addrs[1] = 32'h0;
      addrs[2] = 32'h8;
      pulses = 0;
      last_c = 0;
      c = 0;
      lat = next_latency();
      want = lat + 1;
      @(negedge clk);
      req_address = addrs[0];
      req_operation = LOAD;
      req_valid = 1'b1;
      while (pulses < 3 && c < 100) begin
         @(negedge clk);
         c++;
         if (req_fulfilled === 1'b1) begin
            total++;
            if (c - last_c !== want) begin
               bad++;
               $display("FAIL b2b_spacing pulse=%0d got=%0d want=%0d",
                        pulses, c - last_c, want);
            end
            last_load = mem_m[word_of(addrs[pulses])];
            total++;
            if (req_loaded_word !== last_load) begin
               bad++;
               $display("FAIL b2b_data pulse=%0d got=%h want=%h",
                        pulses, req_loaded_word, last_load);
            end
            pulses++;
            last_c = c;
            if (pulses < 3) begin
               req_address = addrs[pulses];
               lat = next_latency();
               want = lat + 2;
            end
         end
      end
      total++;
      if (pulses !== 3) begin
         bad++;
         $display("FAIL b2b_pulse_count got=%0d want=3", pulses);
      end
      req_valid = 1'b0;
      if (pulses < 3) apply_reset();
      repeat (2) @(negedge clk);
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL b2b_idle_after got=%b want=0", busy);
      end
   endtask

   task automatic test_random();
      int pool [4];
      int l;
      logic [XLEN-1:0] a;
      memory_operation_e op;
      for (int i = 0; i < 4; i++) begin
         pool[i] = int'($urandom_range(16, DEPTH - 1));
         do_req(32'(pool[i] * 4), STORE, $urandom, "rand_preload", l);
      end
      for (int i = 0; i < 16; i++) begin
         a = 32'(pool[$urandom_range(0, 3)] * 4) +
             32'($urandom_range(0, 3)) +
             32'($urandom_range(0, 7) * DEPTH * 4);
         op = memory_operation_e'($urandom_range(0, 3));
         do_req(a, op, $urandom, "rand_op", l);
      end
   endtask

   task automatic test_jitter();
`ifdef HIGHER_MEM_LATENCY_JITTER_EN
      int l;
      apply_reset();
      for (int i = 0; i < 8; i++) begin
         do_req(32'h40, memory_operation_e'($urandom_range(0, 3)),
                $urandom, "jitter_req", l);
         total++;
         if (l < LAT || l > LAT + 3) begin
            bad++;
            $display("FAIL jitter_range got=%0d want %0d..%0d",
                     l, LAT, LAT + 3);
         end
      end
`endif
   endtask

   initial begin
      test_reset();
      test_store_load();
      test_wrap();
      test_other_ops();
      test_reset_abort();
      test_back_to_back();
      test_random();
      test_jitter();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
